wbu: RTL and testbench
======================

# wbu

Write-back unit of the NPC core: accepts completed results from the execute unit (EXU) and the load/store unit (LSU), arbitrates between them, sign/zero-extends load data, and drives the register file write port (rd / wen / wdata). It also keeps a 32-entry busy scoreboard so that decode can stall on RAW/WAW hazards against register file reads (src1/src2) until the write has landed.

## Interface

- No parameters; XLEN fixed at 32, 32 architectural registers.

- clk  in  1  core clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- iss_valid  in  1  decode issues an instruction this cycle
- iss_wen  in  1  issued instruction writes rd
- iss_rd  in  5  destination of issued instruction
- busy  out  32  scoreboard; bit i = write to x[i] outstanding; bit 0 always 0
- exu_valid  in  1  EXU result valid
- exu_ready  out  1  EXU result accepted this cycle
- exu_wen  in  1  result writes rd
- exu_rd  in  5  destination
- exu_data  in  32  result value
- lsu_valid  in  1  LSU load/store complete
- lsu_ready  out  1  LSU result accepted this cycle
- lsu_wen  in  1  1 for loads, 0 for stores
- lsu_rd  in  5  destination
- lsu_funct3  in  3  load type
- lsu_addr_lo  in  2  byte address bits [1:0]
- lsu_rdata  in  32  aligned memory word
- rf_wen  out  1  register file write enable
- rf_rd  out  5  register file write index
- rf_wdata  out  32  register file write data
- commit  out  1  one-cycle pulse per retired instruction

## Operation

- Arbitration: round-robin flag `prio` (0 = LSU first, 1 = EXU first). exu_ready = !lsu_valid || prio; lsu_ready = !exu_valid || !prio. Both valid: exactly one ready. Ready is independent of the requester's own valid.
- `prio` toggles only in cycles where both valids are high (points to loser); otherwise holds.
- Handshake = valid && ready. At most one handshake per cycle.
- Load extension (LSU, lsu_wen=1): 000 lb: byte lane addr_lo, sign-extend; 001 lh: half lane addr_lo[1], sign-extend; 010 lw: full word, addr_lo ignored; 100 lbu, 101 lhu: zero-extend; any other funct3 treated as lw. EXU data passes unmodified.
- Output register: on handshake in cycle N, during cycle N+1 rf_wen = (wen && rd != 0), rf_rd = rd, rf_wdata = extended data, commit = 1. No handshake in N -> rf_wen = 0, commit = 0 in N+1; rf_rd/rf_wdata hold last value.
- wen=0 or rd=0: commit still pulses; no register write.
- Scoreboard: iss_valid && iss_wen && iss_rd != 0 sets busy[iss_rd] at the clock edge. busy[rf_rd] clears at the same edge the register file latches (end of cycle where rf_wen=1). Same-index set and clear on one edge: set wins. busy[0] hard-wired 0.
- Decode guarantees at most one outstanding write per register (stalls while busy[rd]); wbu does not check this.

## Timing

- Reset (rst=1 at posedge): busy = 0, rf_wen = 0, commit = 0, rf_rd = 0, rf_wdata = 0, prio = 0. Pending output write is dropped; handshakes in the reset cycle are ignored. exu_ready/lsu_ready stay combinational during reset.
- Latency handshake -> rf_wen: 1 cycle. Handshake -> busy bit low: 2 cycles (visible in cycle N+2, same cycle register file read returns new value).
- Throughput: one retirement per cycle, no bubbles.
- Back-to-back writes to same rd from different units: order of acceptance; second write wins.

## Test plan

- Single EXU write: exu_valid=1, rd=5, data=0xDEADBEEF in cycle 0 -> exu_ready=1 cycle 0; rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF, commit=1 in cycle 1; cycle 2 rf_wen=0.
- Load extension: lsu_rdata=0x8081_7F80; lb addr_lo=0 -> 0xFFFFFF80; lbu addr_lo=1 -> 0x0000007F; lh addr_lo=2 -> 0xFFFF8081; lhu addr_lo=2 -> 0x00008081; lw -> 0x80817F80.
- Contention: both valid for 4 cycles after reset -> grants LSU, EXU, LSU, EXU; exactly one ready per cycle.
- Scoreboard: issue rd=7 cycle 0 -> busy[7]=1 cycle 1; EXU handshake rd=7 cycle 3 -> rf_wen cycle 4, busy[7]=0 cycle 5; issue rd=7 again in cycle 4 -> busy[7] stays 1.
- x0 / stores: EXU rd=0 wen=1 and LSU store lsu_wen=0 -> commit pulses, rf_wen=0, busy[0]=0 throughout; issue rd=0 never sets busy.
- Reset mid-flight: handshake cycle 0, rst=1 cycle 1 -> rf_wen=0, commit=0, busy=0 from cycle 2; prio=0.

Source files
------------

// File: rtl/wbu.sv
// Write-back unit: arbitrates EXU/LSU results, extends load data, drives the
// register file write port and tracks outstanding writes in a busy scoreboard.
module wbu (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  input  logic        iss_wen,
  input  logic [4:0]  iss_rd,
  output logic [31:0] busy,
  input  logic        exu_valid,
  output logic        exu_ready,
  input  logic        exu_wen,
  input  logic [4:0]  exu_rd,
  input  logic [31:0] exu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_wen,
  input  logic [4:0]  lsu_rd,
  input  logic [2:0]  lsu_funct3,
  input  logic [1:0]  lsu_addr_lo,
  input  logic [31:0] lsu_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        commit
);

  logic        prio;
  logic        exu_hs;
  logic        lsu_hs;
  logic [31:0] busy_q;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Ready does not look at the requester's own valid, so at most one side
  // can complete a handshake when both are presenting.
  assign exu_ready = !lsu_valid || prio;
  assign lsu_ready = !exu_valid || !prio;
  assign exu_hs    = exu_valid && exu_ready;
  assign lsu_hs    = lsu_valid && lsu_ready;

  always_ff @(posedge clk) begin
    if (rst)
      prio <= 1'b0;
    else if (exu_valid && lsu_valid)
      prio <= !prio;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= 32'd0;
      commit   <= 1'b0;
    end else begin
      commit <= exu_hs || lsu_hs;
      rf_wen <= 1'b0;
      if (lsu_hs) begin
        rf_wen   <= lsu_wen && (lsu_rd != 5'd0);
        rf_rd    <= lsu_rd;
        rf_wdata <= load_ext(lsu_funct3, lsu_addr_lo, lsu_rdata);
      end else if (exu_hs) begin
        rf_wen   <= exu_wen && (exu_rd != 5'd0);
        rf_rd    <= exu_rd;
        rf_wdata <= exu_data;
      end
    end
  end

  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (iss_valid && iss_wen)
      set_vec[iss_rd] = 1'b1;
    if (rf_wen)
      clr_vec[rf_rd] = 1'b1;
  end

  // A new issue to the register retiring this cycle must stay busy, so the
  // set is applied after the clear; bit 0 is masked off permanently.
  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= 32'd0;
    else
      busy_q <= ((busy_q & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: a per-cycle reference model plus hand-computed
// literal expectations for the key scenarios.
module tb_wbu;

  logic        clk;
  logic        rst;
  logic        iss_valid, iss_wen;
  logic [4:0]  iss_rd;
  logic [31:0] busy;
  logic        exu_valid, exu_ready, exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready, lsu_wen;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic [31:0] lsu_rdata;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        commit;

  wbu dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd), .busy(busy),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
    .lsu_rd(lsu_rd), .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .lsu_rdata(lsu_rdata),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .commit(commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;
  bit chkEn = 0;

  // Reference model state: what the outputs must show in the current cycle.
  logic [31:0] mBusy = 32'd0;
  logic        mWen = 1'b0;
  logic        mCommit = 1'b0;
  logic [4:0]  mRd = 5'd0;
  logic [31:0] mWdata = 32'd0;
  logic        exuTurn = 1'b0;
  logic        exuWin, lsuWin;

  function automatic logic [31:0] extModel(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] sb, sh;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    sb  = w >> (8 * int'(lo));
    sh  = w >> (16 * int'(lo[1]));
    b8  = sb[7:0];
    h16 = sh[15:0];
    case (f3)
      3'b000:  return 32'(b8);
      3'b001:  return 32'(h16);
      3'b100:  return {24'd0, sb[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mBusy = 32'd0; mWen = 1'b0; mCommit = 1'b0; mRd = 5'd0; mWdata = 32'd0;
      exuTurn = 1'b0;
    end else begin
      if (exu_valid && lsu_valid) begin
        exuWin = exuTurn;
        lsuWin = !exuTurn;
      end else begin
        exuWin = exu_valid;
        lsuWin = lsu_valid;
      end
      if (mWen) mBusy[mRd] = 1'b0;
      if (iss_valid && iss_wen && iss_rd != 5'd0) mBusy[iss_rd] = 1'b1;
      mCommit = exuWin || lsuWin;
      mWen = 1'b0;
      if (lsuWin) begin
        mWen = lsu_wen && lsu_rd != 5'd0;
        mRd = lsu_rd;
        mWdata = extModel(lsu_funct3, lsu_addr_lo, lsu_rdata);
      end else if (exuWin) begin
        mWen = exu_wen && exu_rd != 5'd0;
        mRd = exu_rd;
        mWdata = exu_data;
      end
      if (exu_valid && lsu_valid) exuTurn = !exuTurn;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("model_busy", busy, mBusy);
      checkOutput("model_rf_wen", {31'd0, rf_wen}, {31'd0, mWen});
      checkOutput("model_commit", {31'd0, commit}, {31'd0, mCommit});
      checkOutput("model_exu_ready", {31'd0, exu_ready}, {31'd0, !lsu_valid || exuTurn});
      checkOutput("model_lsu_ready", {31'd0, lsu_ready}, {31'd0, !exu_valid || !exuTurn});
      if (mWen) begin
        checkOutput("model_rf_rd", {27'd0, rf_rd}, {27'd0, mRd});
        checkOutput("model_rf_wdata", rf_wdata, mWdata);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    exu_valid = 0; exu_wen = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_wen = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_addr_lo = 0; lsu_rdata = 0;
    iss_valid = 0; iss_wen = 0; iss_rd = 0;
  endtask

  task automatic applyStimulus(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                               input logic lv, input logic lw, input logic [4:0] lrd,
                               input logic [2:0] f3, input logic [1:0] lo,
                               input logic [31:0] rdata);
    exu_valid = ev; exu_wen = 1'b1; exu_rd = erd; exu_data = ed;
    lsu_valid = lv; lsu_wen = lw; lsu_rd = lrd; lsu_funct3 = f3;
    lsu_addr_lo = lo; lsu_rdata = rdata;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd);
    iss_valid = v; iss_wen = v; iss_rd = rd;
  endtask

  logic [2:0]  f3Tab  [8];
  logic [1:0]  loTab  [8];
  logic [31:0] expTab [8];

  initial begin
    f3Tab  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b011};
    loTab  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2};
    expTab = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF8081, 32'h00008081,
               32'h80817F80, 32'hFFFFFF80, 32'h00007F80, 32'h80817F80};

    idle();
    rst = 1;
    cyc();
    chkEn = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 32'd0);
    checkOutput("reset_rf_wen", {31'd0, rf_wen}, 32'd0);
    checkOutput("reset_commit", {31'd0, commit}, 32'd0);
    checkOutput("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
    checkOutput("reset_rf_wdata", rf_wdata, 32'd0);

    // single EXU write
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("exu_ready_c0", {31'd0, exu_ready}, 32'd1);
    cyc(); idle();
    @(negedge clk);
    checkOutput("exu_rf_wen_c1", {31'd0, rf_wen}, 32'd1);
    checkOutput("exu_rf_rd_c1", {27'd0, rf_rd}, 32'd5);
    checkOutput("exu_rf_wdata_c1", rf_wdata, 32'hDEADBEEF);
    checkOutput("exu_commit_c1", {31'd0, commit}, 32'd1);
    cyc();
    @(negedge clk);
    checkOutput("exu_rf_wen_c2", {31'd0, rf_wen}, 32'd0);

    // load extension
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 5'(10 + i), f3Tab[i], loTab[i], 32'h80817F80);
      cyc(); idle();
      @(negedge clk);
      checkOutput("load_ext", rf_wdata, expTab[i]);
    end

    // contention right after reset
    rst = 1;
    cyc();
    rst = 0;
    applyStimulus(1, 5'd1, 32'h100, 1, 1, 5'd2, 3'b010, 0, 32'h200);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("grant", {30'd0, exu_ready, lsu_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
      cyc();
    end
    idle();

    // back-to-back writes to one register from both units
    applyStimulus(0, 0, 0, 1, 1, 5'd6, 3'b010, 0, 32'h11111111);
    cyc();
    applyStimulus(1, 5'd6, 32'h22222222, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("b2b_first", rf_wdata, 32'h11111111);
    cyc(); idle();
    @(negedge clk);
    checkOutput("b2b_second", rf_wdata, 32'h22222222);
    checkOutput("b2b_wen", {31'd0, rf_wen}, 32'd1);

    // scoreboard set/clear timing
    cyc();
    issue(1, 5'd7);
    cyc(); issue(0, 0);
    @(negedge clk);
    checkOutput("sb_set", {31'd0, busy[7]}, 32'd1);
    cyc(); cyc();
    applyStimulus(1, 5'd7, 32'h1234, 0, 0, 0, 0, 0, 0);
    cyc(); idle(); issue(1, 5'd7);
    @(negedge clk);
    checkOutput("sb_rf_wen", {31'd0, rf_wen}, 32'd1);
    checkOutput("sb_busy_c4", {31'd0, busy[7]}, 32'd1);
    cyc(); issue(0, 0);
    @(negedge clk);
    checkOutput("sb_set_wins", {31'd0, busy[7]}, 32'd1);
    applyStimulus(1, 5'd7, 32'h5678, 0, 0, 0, 0, 0, 0);
    cyc(); idle();
    @(negedge clk);
    checkOutput("sb_busy_wb", {31'd0, busy[7]}, 32'd1);
    cyc();
    @(negedge clk);
    checkOutput("sb_clear", {31'd0, busy[7]}, 32'd0);

    // x0 and store retirements
    applyStimulus(1, 5'd0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0);
    cyc(); idle();
    @(negedge clk);
    checkOutput("x0_commit", {31'd0, commit}, 32'd1);
    checkOutput("x0_rf_wen", {31'd0, rf_wen}, 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 5'd3, 3'b010, 0, 32'h0BADF00D);
    cyc(); idle();
    @(negedge clk);
    checkOutput("store_commit", {31'd0, commit}, 32'd1);
    checkOutput("store_rf_wen", {31'd0, rf_wen}, 32'd0);
    issue(1, 5'd0);
    cyc(); issue(0, 0);
    @(negedge clk);
    checkOutput("x0_busy", busy, 32'd0);

    // reset in flight
    applyStimulus(1, 5'd1, 32'h1, 1, 1, 5'd2, 3'b010, 0, 32'h2);
    cyc();
    applyStimulus(1, 5'd9, 32'hAA, 0, 0, 0, 0, 0, 0);
    issue(1, 5'd12);
    cyc();
    rst = 1;
    applyStimulus(1, 5'd4, 32'hBB, 0, 0, 0, 0, 0, 0);
    issue(0, 0);
    @(negedge clk);
    checkOutput("mid_rf_wen", {31'd0, rf_wen}, 32'd1);
    checkOutput("mid_busy12", {31'd0, busy[12]}, 32'd1);
    cyc();
    rst = 0;
    applyStimulus(1, 5'd1, 32'h1, 1, 1, 5'd2, 3'b010, 0, 32'h2);
    @(negedge clk);
    checkOutput("post_rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    checkOutput("post_rst_commit", {31'd0, commit}, 32'd0);
    checkOutput("post_rst_busy", busy, 32'd0);
    checkOutput("post_rst_grant", {30'd0, exu_ready, lsu_ready}, 32'd1);
    cyc(); idle();
    cyc(); cyc();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
